// File: rtl/j_uart_pkg.sv
// Shared definitions for the Jerry UART schedulers: FSM encoding and default sizing.
package j_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ACK  = 2'd2,
        ST_BRK  = 2'd3
    } sched_state_t;

    localparam int DEPTH_DEF  = 4;
    localparam int ACK_TO_DEF = 15;

endpackage

// File: rtl/j_txfifo.sv
// Byte FIFO for the transmit scheduler: circular buffer with occupancy count.
module j_txfifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          resetl,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    // A full FIFO refuses a push even when the head is popped in the same cycle.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetl) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_reg <= count_reg + 1'b1;
            end else if (!push_ok && pop_ok) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    assign dout  = mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/j_txsched.sv
// Transmit scheduler: round-robin arbitration of two byte sources into a FIFO,
// drained into the UART holding register, with break sequencing behind queued data.
module j_txsched
    import j_uart_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int AW     = $clog2(DEPTH_DEF),
    parameter int ACK_TO = ACK_TO_DEF
) (
    input  logic          clk,
    input  logic          resetl,
    input  logic          r0_valid,
    input  logic [7:0]    r0_data,
    output logic          r0_ready,
    input  logic          r1_valid,
    input  logic [7:0]    r1_data,
    output logic          r1_ready,
    input  logic          brk_req,
    input  logic          tbe,
    output logic [7:0]    tdout,
    output logic          u2dwr,
    output logic          txbrk,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          err
);

    localparam int TW = $clog2(ACK_TO + 1);

    sched_state_t  state_reg, state_next;
    logic          prio_reg;
    logic [7:0]    tdout_reg;
    logic          u2dwr_reg;
    logic          txbrk_reg;
    logic          err_reg, err_next;
    logic [TW-1:0] to_cnt_reg, to_cnt_next;

    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_head;
    logic          push;
    logic          pop;
    logic          load;
    logic [7:0]    push_data;

    assign r0_ready  = ~fifo_full & r0_valid & (~r1_valid | ~prio_reg);
    assign r1_ready  = ~fifo_full & r1_valid & (~r0_valid | prio_reg);
    assign push      = r0_ready | r1_ready;
    assign push_data = r0_ready ? r0_data : r1_data;

    j_txfifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk    (clk),
        .resetl (resetl),
        .push   (push),
        .pop    (pop),
        .din    (push_data),
        .dout   (fifo_head),
        .count  (count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_comb begin
        state_next  = state_reg;
        pop         = 1'b0;
        load        = 1'b0;
        err_next    = err_reg;
        to_cnt_next = to_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                // Break only starts once every queued byte has been handed over.
                if (brk_req && fifo_empty && tbe) begin
                    state_next = ST_BRK;
                end else if (!fifo_empty && tbe) begin
                    state_next = ST_LOAD;
                    pop        = 1'b1;
                    load       = 1'b1;
                end
            end
            ST_LOAD: begin
                state_next  = ST_ACK;
                to_cnt_next = '0;
            end
            ST_ACK: begin
                if (!tbe) begin
                    state_next = ST_IDLE;
                end else if (to_cnt_reg == TW'(ACK_TO - 1)) begin
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    to_cnt_next = to_cnt_reg + 1'b1;
                end
            end
            ST_BRK: begin
                if (!brk_req) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetl) begin
            state_reg  <= ST_IDLE;
            prio_reg   <= 1'b0;
            tdout_reg  <= 8'h00;
            u2dwr_reg  <= 1'b0;
            txbrk_reg  <= 1'b0;
            err_reg    <= 1'b0;
            to_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (r0_valid && r1_valid && push) begin
                prio_reg <= ~prio_reg;
            end
            if (load) begin
                tdout_reg <= fifo_head;
            end
            // Strobe and break are decoded from the next state so they leave a flop.
            u2dwr_reg  <= (state_next == ST_LOAD);
            txbrk_reg  <= (state_next == ST_BRK);
            err_reg    <= err_next;
            to_cnt_reg <= to_cnt_next;
        end
    end

    assign tdout = tdout_reg;
    assign u2dwr = u2dwr_reg;
    assign txbrk = txbrk_reg;
    assign empty = fifo_empty;
    assign err   = err_reg;

endmodule

// File: doc/j_txsched.md
Name: j_txsched

Overview:
- Transmit scheduler that sits in front of the Jerry UART transmitter.
- Arbitrates byte writes from two requesters (0 = CPU/host, 1 = DSP) into a shared DEPTH-entry FIFO.
- Drains the FIFO into the transmitter's holding register: presents data and pulses the data-write strobe whenever the transmitter reports buffer empty.
- Sequences break requests so a break only begins after all queued data has been handed over.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- AW, 2, log2(DEPTH).
- ACK_TO, 15, cycles to wait for tbe to fall after a write strobe before declaring a handover fault.

Ports:
- clk  in  1  system clock.
- resetl  in  1  synchronous active-low reset.
- r0_valid  in  1  requester 0 has a byte.
- r0_data  in  8  requester 0 byte.
- r0_ready  out  1  requester 0 byte accepted this cycle (valid & ready).
- r1_valid  in  1  requester 1 has a byte.
- r1_data  in  8  requester 1 byte.
- r1_ready  out  1  requester 1 byte accepted this cycle.
- brk_req  in  1  level; request a line break.
- tbe  in  1  transmitter buffer empty, from the UART transmitter.
- tdout  out  8  byte to transmitter data inputs din_0..din_7; registered, held stable.
- u2dwr  out  1  one-cycle data-write strobe to the transmitter.
- txbrk  out  1  break control to the transmitter; registered.
- count  out  AW+1  FIFO occupancy, 0..DEPTH.
- empty  out  1  count == 0.
- err  out  1  sticky handover timeout; cleared only by reset.

Behaviour:
- Clock and reset: one clock, clk. Reset resetl is synchronous, active-low, sampled on the rising edge of clk.
- Reset values: count=0, empty=1, tdout=0, u2dwr=0, txbrk=0, err=0, FSM=IDLE, prio=0, FIFO pointers=0.
- Arbitration (combinational ready):
  - full = (count == DEPTH).
  - r0_ready = !full & r0_valid & (!r1_valid | prio==0).
  - r1_ready = !full & r1_valid & (!r0_valid | prio==1).
  - At most one push per cycle.
  - prio toggles only on a cycle where both valids are high and a push occurs. Round-robin, so no requester starves.
  - Push is refused when full, even if a pop occurs in the same cycle.
- FIFO:
  - Circular buffer with AW-bit read/write pointers; pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leaves count unchanged.
  - A popped entry is never pushed into in the same cycle.
- FSM states IDLE, LOAD, ACK, BRK:
  - IDLE: if brk_req & empty & tbe -> BRK, and txbrk goes to 1 next cycle. Else if !empty & tbe -> LOAD, tdout <= head, pop. Break has priority only when the FIFO is empty; queued data drains first.
  - LOAD: u2dwr=1 for exactly this one cycle; tdout stable -> ACK.
  - ACK: wait for tbe=0 -> IDLE. A timeout counter counts cycles in ACK; at ACK_TO cycles with tbe still 1, set err=1 and go to IDLE. No retransmit; the byte counts as sent.
  - BRK: txbrk=1 held. When brk_req=0, txbrk clears next cycle -> IDLE. Pushes are still accepted during BRK; no pops.
- Latency: byte pushed into an empty FIFO with tbe=1 gives u2dwr 2 cycles after the push edge (push edge -> IDLE sees !empty -> LOAD).
- tdout changes only on the transition into LOAD.
- brk_req dropping before BRK is entered has no effect.
- Reset mid-operation (any state): return to reset values on the next edge. FIFO content is discarded and u2dwr never glitches high.

Decomposition:
- Shared package (j_uart_pkg): FSM state encoding constants (IDLE=0, LOAD=1, ACK=2, BRK=3) and the default DEPTH/ACK_TO constants, reusable by the receiver-side scheduler.
- One natural sub-module: j_txfifo. It holds the DEPTH x 8 storage, pointers, count, full/empty, with push/pop/data in/out.
- Arbiter and FSM stay in j_txsched.

Test Plan:
- Reset, then r0 pushes 0x55 with tbe=1 -> r0_ready=1 that cycle; u2dwr high 2 cycles later with tdout=0x55; tbe dropped 2 cycles after the strobe -> FSM back to IDLE, count=0.
- Both requesters valid continuously (r0=0xA0.., r1=0xB0..), tbe=0 -> pushes alternate r0, r1, r0, r1; after 4 pushes r0_ready=r1_ready=0 and count=4.
- FIFO full, then tbe pulses -> bytes emerge in push order A0, B0, A1, B1; count decrements per pop; read pointer wraps at DEPTH without data loss.
- brk_req=1 with 3 bytes queued -> all 3 strobed first; txbrk=1 only once empty & tbe; brk_req=0 -> txbrk=0 next cycle; a byte pushed during break is sent afterwards.
- tbe held at 1 after a strobe -> err=1 after exactly 15 ACK cycles; FSM returns to IDLE; next byte is still delivered.
- resetl=0 asserted in ACK with count=2 -> next edge count=0, u2dwr=0, txbrk=0, err=0; no strobe until a new push.
